// File: rtl/control_unit.sv
// Instruction sequencer and execute stage: owns state, pc, accumulator and flags,
// steers the upstream fetcher between ROM and RAM and issues RAM store strobes.
module control_unit #(
  parameter int BITS       = 8,
  parameter int STATE_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BITS-1:0]       instr,
  input  logic [BITS-1:0]       ram_data,
  output logic [STATE_BITS-1:0] state,
  output logic                  fetch_source,
  output logic [BITS-1:0]       pc,
  output logic [BITS-1:0]       ram_addr,
  output logic                  ram_we,
  output logic [BITS-1:0]       ram_wdata,
  output logic [BITS-1:0]       acc,
  output logic                  zero,
  output logic                  carry,
  output logic                  halted,
  output logic                  illegal
);

  typedef enum logic [STATE_BITS-1:0] {
    S_RESET   = STATE_BITS'(0),
    S_FETCH   = STATE_BITS'(1),
    S_DECODE  = STATE_BITS'(2),
    S_EXECUTE = STATE_BITS'(3),
    S_LOAD    = STATE_BITS'(4),
    S_HALT    = STATE_BITS'(5)
  } state_t;

  localparam logic FETCH_ROM = 1'b0;
  localparam logic FETCH_RAM = 1'b1;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q;
  logic [3:0]      opcode;
  logic [3:0]      imm;
  logic            ld_pending;
  logic [3:0]      dec_op;
  logic [3:0]      dec_imm;
  logic [BITS:0]   add_sum;
  logic [BITS-1:0] sub_diff;

  assign state     = state_q;
  assign ram_wdata = acc;
  assign dec_op    = instr[BITS-1 -: 4];
  assign dec_imm   = instr[3:0];
  assign add_sum   = {1'b0, acc} + (BITS+1)'(imm);
  assign sub_diff  = acc - BITS'(imm);

  // Strobes (ram_we, illegal) are armed at DECODE so they are high for exactly the EXECUTE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_RESET;
      pc           <= '0;
      acc          <= '0;
      ram_addr     <= '0;
      zero         <= 1'b0;
      carry        <= 1'b0;
      ram_we       <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      ld_pending   <= 1'b0;
      fetch_source <= FETCH_ROM;
      opcode       <= '0;
      imm          <= '0;
    end else begin
      ram_we  <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH: begin
          if (ld_pending) begin
            fetch_source <= FETCH_ROM;
            state_q      <= S_LOAD;
          end else begin
            pc      <= pc + 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          opcode <= dec_op;
          imm    <= dec_imm;
          case (dec_op)
            OP_LD: begin
              ld_pending   <= 1'b1;
              fetch_source <= FETCH_RAM;
              ram_addr     <= BITS'(dec_imm);
              state_q      <= S_FETCH;
            end
            OP_HALT: begin
              halted  <= 1'b1;
              state_q <= S_HALT;
            end
            default: begin
              if (dec_op == OP_ST) begin
                ram_we   <= 1'b1;
                ram_addr <= BITS'(dec_imm);
              end
              if (dec_op >= 4'h8 && dec_op <= 4'hE) illegal <= 1'b1;
              state_q <= S_EXECUTE;
            end
          endcase
        end
        S_EXECUTE: begin
          case (opcode)
            OP_LDI: begin
              acc  <= BITS'(imm);
              zero <= (imm == 4'h0);
            end
            OP_ADDI: begin
              {carry, acc} <= add_sum;
              zero         <= (add_sum[BITS-1:0] == '0);
            end
            OP_SUBI: begin
              acc   <= sub_diff;
              carry <= (acc < BITS'(imm));
              zero  <= (sub_diff == '0);
            end
            OP_JMP: pc <= BITS'(imm);
            OP_JZ:  if (zero) pc <= BITS'(imm);
            default: ;
          endcase
          state_q <= S_FETCH;
        end
        S_LOAD: begin
          acc        <= ram_data;
          zero       <= (ram_data == '0);
          ld_pending <= 1'b0;
          state_q    <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a ROM/RAM fetcher stand-in plus an instruction-level
// interpreter that predicts architectural state after every instruction.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [7:0] instr_q;
  logic [7:0] ram_q;
  logic [2:0] state;
  logic       fetch_source;
  logic [7:0] pc;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] acc;
  logic       zero;
  logic       carry;
  logic       halted;
  logic       illegal;

  logic [7:0] rom      [256];
  logic [7:0] ram      [256];
  logic [7:0] ram_init [256];
  logic       ram_load;

  logic [7:0] m_pc;
  logic [7:0] m_acc;
  logic       m_zero;
  logic       m_carry;
  logic [7:0] m_ram [256];

  int checks;
  int passes;

  control_unit #(.BITS(8), .STATE_BITS(3)) dut (
    .clk(clk), .reset(reset), .instr(instr_q), .ram_data(ram_q),
    .state(state), .fetch_source(fetch_source), .pc(pc), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .acc(acc), .zero(zero),
    .carry(carry), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetcher stand-in: latches ROM or RAM during FETCH, performs RAM stores.
  always @(posedge clk) begin
    if (state == 3'd1) begin
      if (fetch_source) ram_q <= ram[ram_addr];
      else              instr_q <= rom[pc];
    end
    if (ram_load)     ram <= ram_init;
    else if (ram_we)  ram[ram_addr] <= ram_wdata;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i]      = 8'h00;
      ram_init[i] = 8'h00;
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_acc = 8'h00; m_zero = 1'b0; m_carry = 1'b0;
    for (int i = 0; i < 256; i++) m_ram[i] = ram_init[i];
  endtask

  task automatic do_reset();
    reset = 1'b1; ram_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ram_load = 1'b0; reset = 1'b0;
    model_reset();
  endtask

  task automatic enter_fetch();
    @(negedge clk);
  endtask

  // Executes n instructions starting in FETCH; checks state and side effects after each.
  task automatic run_insts(input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] ins, e_addr, e_data, o_addr, o_data;
      logic [3:0] op, imm;
      logic [8:0] sum;
      logic       e_we, e_ill, e_fs;
      int         lat, we_n, ill_n, fs_n;
      ins = rom[m_pc]; op = ins[7:4]; imm = ins[3:0];
      m_pc = m_pc + 8'd1;
      lat = 3; e_we = 1'b0; e_ill = 1'b0; e_fs = 1'b0; e_addr = 8'h00; e_data = 8'h00;
      case (op)
        4'h1: begin m_acc = {4'h0, imm}; m_zero = (m_acc == 8'h00); end
        4'h2: begin
          sum = {1'b0, m_acc} + {5'h00, imm};
          m_carry = sum[8]; m_acc = sum[7:0]; m_zero = (m_acc == 8'h00);
        end
        4'h3: begin
          m_carry = (m_acc < {4'h0, imm});
          m_acc = m_acc - {4'h0, imm}; m_zero = (m_acc == 8'h00);
        end
        4'h4: begin
          lat = 4; e_fs = 1'b1;
          m_acc = m_ram[{4'h0, imm}]; m_zero = (m_acc == 8'h00);
        end
        4'h5: begin
          e_we = 1'b1; e_addr = {4'h0, imm}; e_data = m_acc;
          m_ram[{4'h0, imm}] = m_acc;
        end
        4'h6: m_pc = {4'h0, imm};
        4'h7: if (m_zero) m_pc = {4'h0, imm};
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: e_ill = 1'b1;
        default: ;
      endcase
      we_n = 0; ill_n = 0; fs_n = 0; o_addr = 8'h00; o_data = 8'h00;
      repeat (lat) begin
        @(negedge clk);
        if (ram_we) begin we_n++; o_addr = ram_addr; o_data = ram_wdata; end
        if (illegal) ill_n++;
        if (fetch_source) fs_n++;
      end
      checks++;
      if ({state, pc, acc, zero, carry} !== {3'd1, m_pc, m_acc, m_zero, m_carry})
        $display("[TB] FAIL arch instr=%h: got st/pc/acc/z/c=%h/%h/%h/%b/%b expected 1/%h/%h/%b/%b",
                 ins, state, pc, acc, zero, carry, m_pc, m_acc, m_zero, m_carry);
      else passes++;
      checks++;
      if ({4'(we_n), 4'(ill_n), 4'(fs_n), o_addr, o_data} !==
          {3'b000, e_we, 3'b000, e_ill, 3'b000, e_fs, e_addr, e_data})
        $display("[TB] FAIL side instr=%h: got we/ill/fs/addr/data=%0d/%0d/%0d/%h/%h expected %0d/%0d/%0d/%h/%h",
                 ins, we_n, ill_n, fs_n, o_addr, o_data, e_we, e_ill, e_fs, e_addr, e_data);
      else passes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({state, fetch_source, pc, ram_addr, ram_we, acc, zero, carry, halted, illegal} !== 33'd0)
      $display("[TB] FAIL reset_state: got %h expected 0",
               {state, fetch_source, pc, ram_addr, ram_we, acc, zero, carry, halted, illegal});
    else passes++;
  endtask

  task automatic test_basic_seq();
    logic [20:0] seq;
    logic [7:0]  acc_mid;
    clear_mem();
    rom[0] = 8'h13; rom[1] = 8'h24;
    do_reset();
    seq = {18'h0, state};
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      seq = {seq[17:0], state};
      if (i == 4) acc_mid = acc;
    end
    checks++;
    if (seq !== {3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3})
      $display("[TB] FAIL state_seq: got %h expected %h", seq, {3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3});
    else passes++;
    @(negedge clk);
    checks++;
    if ({acc_mid, acc, pc, zero, carry} !== {8'h03, 8'h07, 8'h02, 2'b00})
      $display("[TB] FAIL basic_result: got %h expected %h", {acc_mid, acc, pc, zero, carry},
               {8'h03, 8'h07, 8'h02, 2'b00});
    else passes++;
  endtask

  task automatic test_add_sub();
    clear_mem();
    rom[0] = 8'h1F; rom[1] = 8'h21;
    do_reset(); enter_fetch(); run_insts(2);
    checks++;
    if ({acc, carry, zero} !== {8'h10, 2'b00})
      $display("[TB] FAIL addi: got %h expected %h", {acc, carry, zero}, {8'h10, 2'b00});
    else passes++;
    clear_mem();
    rom[0] = 8'h10; rom[1] = 8'h31;
    do_reset(); enter_fetch(); run_insts(2);
    checks++;
    if ({acc, carry, zero} !== {8'hFF, 2'b10})
      $display("[TB] FAIL subi_borrow: got %h expected %h", {acc, carry, zero}, {8'hFF, 2'b10});
    else passes++;
  endtask

  task automatic test_store_load();
    clear_mem();
    rom[0] = 8'h1A; rom[1] = 8'h55; rom[2] = 8'h40; rom[3] = 8'h05;
    ram_init[5] = 8'hC3;
    do_reset(); enter_fetch(); run_insts(3);
    checks++;
    if ({acc, zero, ram[5]} !== {8'h00, 1'b1, 8'h0A})
      $display("[TB] FAIL store_load: got %h expected %h", {acc, zero, ram[5]}, {8'h00, 1'b1, 8'h0A});
    else passes++;
    run_insts(1);
  endtask

  task automatic test_jz_illegal();
    clear_mem();
    rom[0] = 8'h10; rom[1] = 8'h73;
    do_reset(); enter_fetch(); run_insts(2);
    checks++;
    if (pc !== 8'h03) $display("[TB] FAIL jz_taken: got %h expected 03", pc);
    else passes++;
    clear_mem();
    rom[0] = 8'h11; rom[1] = 8'h73; rom[2] = 8'h1A; rom[3] = 8'h93; rom[4] = 8'h00;
    do_reset(); enter_fetch(); run_insts(2);
    checks++;
    if (pc !== 8'h02) $display("[TB] FAIL jz_not_taken: got %h expected 02", pc);
    else passes++;
    run_insts(3);
    checks++;
    if (acc !== 8'h0A) $display("[TB] FAIL illegal_acc: got %h expected 0a", acc);
    else passes++;
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    do_reset(); enter_fetch(); run_insts(256);
    checks++;
    if (pc !== 8'h00) $display("[TB] FAIL pc_wrap: got %h expected 00", pc);
    else passes++;
  endtask

  task automatic test_halt();
    int bad;
    clear_mem();
    rom[0] = 8'h1A; rom[1] = 8'hF0;
    do_reset(); enter_fetch(); run_insts(1);
    @(negedge clk);
    @(negedge clk);
    bad = 0;
    repeat (20) begin
      if (state !== 3'd5 || pc !== 8'h02 || acc !== 8'h0A || halted !== 1'b1 || ram_we !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0)
      $display("[TB] FAIL halt_hold: got %0d bad cycles (st=%0d pc=%h acc=%h h=%b) expected 0", bad, state, pc, acc, halted);
    else passes++;
  endtask

  task automatic test_async_reset();
    clear_mem();
    rom[0] = 8'h1A; rom[1] = 8'h55;
    do_reset(); enter_fetch(); run_insts(1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr} !== {1'b1, 8'h05})
      $display("[TB] FAIL st_strobe: got %h expected 105", {ram_we, ram_addr});
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ram_we, state, pc, acc, ram_addr} !== 28'd0)
      $display("[TB] FAIL async_reset_st: got %h expected 0", {ram_we, state, pc, acc, ram_addr});
    else passes++;
    @(negedge clk);
    reset = 1'b0; model_reset(); enter_fetch(); run_insts(2);

    clear_mem();
    rom[0] = 8'h40; ram_init[0] = 8'h77;
    do_reset(); enter_fetch();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({fetch_source, pc} !== {1'b1, 8'h01})
      $display("[TB] FAIL ld_fetch_ram: got %h expected 101", {fetch_source, pc});
    else passes++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, fetch_source, pc, acc, zero} !== 21'd0)
      $display("[TB] FAIL async_reset_ld: got %h expected 0", {state, fetch_source, pc, acc, zero});
    else passes++;
    rom[0] = 8'h00;
    @(negedge clk);
    reset = 1'b0; model_reset(); enter_fetch(); run_insts(1);
  endtask

  task automatic test_random();
    int bad;
    clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i]      = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      ram_init[i] = 8'($urandom);
    end
    do_reset(); enter_fetch(); run_insts(200);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) bad++;
    checks++;
    if (bad !== 0) $display("[TB] FAIL random_ram: got %0d differing bytes expected 0", bad);
    else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    reset = 1'b1; ram_load = 1'b0;
    clear_mem();
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_seq();
    test_add_sub();
    test_store_load();
    test_jz_illegal();
    test_pc_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
